// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver/transmitter FSM states, baud divisor.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned bps);
      return clk_freq / bps;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module uart_rx_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority voting, false-start rejection,
// per-byte parity/framing flags, buffered valid/ready output.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 10_000_000,
   parameter int unsigned UART_BPS   = 128000,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic                        uart_rxd,
   output logic [DATA_BITS-1:0]        rx_data,
   output logic                        rx_parity_err,
   output logic                        rx_frame_err,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic                        overrun,
   output logic                        rx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned BPS_CNT = baud_div(CLK_FREQ, UART_BPS);
   localparam int unsigned CW      = $clog2(BPS_CNT);
   localparam int unsigned IW      = $clog2(DATA_BITS);
   localparam int unsigned WW      = DATA_BITS + 2;
   localparam logic [CW-1:0] SMP0     = CW'(BPS_CNT / 2 - 1);
   localparam logic [CW-1:0] SMP1     = CW'(BPS_CNT / 2);
   localparam logic [CW-1:0] SMP2     = CW'(BPS_CNT / 2 + 1);
   localparam logic [CW-1:0] BCNT_END = CW'(BPS_CNT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
   localparam logic          LAST_STP = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
      $error("uart_rx_param: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
   end
   if (PARITY > PAR_ODD) begin : gen_bad_parity
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
      $error("uart_rx_param: FIFO_DEPTH must be a power of two >= 2");
   end
   if (BPS_CNT < 8) begin : gen_bad_baud
      $error("uart_rx_param: CLK_FREQ/UART_BPS must be >= 8");
   end

   uart_state_e          state_q, state_d;
   logic                 rxd_s1_q, rxd_s2_q, rxd_prev_q;
   logic [1:0]           sync_vld_q;
   logic                 armed_q;
   logic [CW-1:0]        bcnt_q;
   logic [1:0]           smp_q;
   logic [IW-1:0]        bit_idx_q;
   logic                 stop_idx_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 par_acc_q, par_err_q, frame_err_q;
   logic                 maj, decide, wrap, fall;
   logic                 push;
   logic [WW-1:0]        push_word, head;
   logic                 fifo_full, fifo_empty;

   assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s2_q) | (smp_q[1] & rxd_s2_q);
   assign decide = (bcnt_q == SMP2);
   assign wrap   = (bcnt_q == BCNT_END);
   assign fall   = armed_q & rxd_prev_q & ~rxd_s2_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (fall) state_d = StStart;
         StStart: begin
            if (decide && maj) state_d = StIdle;
            else if (wrap)     state_d = StData;
         end
         StData: begin
            if (wrap && bit_idx_q == LAST_BIT) state_d = (PARITY != PAR_NONE) ? StParity : StStop;
         end
         StParity: if (wrap) state_d = StStop;
         StStop:   if (decide && stop_idx_q == LAST_STP) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      rx_busy   = (state_q != StIdle);
      push      = (state_q == StStop) && decide && (stop_idx_q == LAST_STP);
      push_word = {frame_err_q | ~maj, par_err_q, data_q};
      overrun   = push && fifo_full && !rx_ready;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_s1_q    <= 1'b1;
         rxd_s2_q    <= 1'b1;
         rxd_prev_q  <= 1'b1;
         sync_vld_q  <= '0;
         armed_q     <= 1'b0;
         bcnt_q      <= '0;
         smp_q       <= '0;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         data_q      <= '0;
         par_acc_q   <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rxd_s1_q   <= uart_rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
         // Reset values of the synchroniser are not line samples; arm only on a real high.
         sync_vld_q <= {sync_vld_q[0], 1'b1};
         if (sync_vld_q[1] && rxd_s2_q) armed_q <= 1'b1;

         if (state_q == StIdle || state_d == StIdle) bcnt_q <= '0;
         else if (wrap)                              bcnt_q <= '0;
         else                                        bcnt_q <= bcnt_q + 1'b1;

         if (bcnt_q == SMP0) smp_q[0] <= rxd_s2_q;
         if (bcnt_q == SMP1) smp_q[1] <= rxd_s2_q;

         if (state_q == StIdle) begin
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            data_q      <= '0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
         end
         if (state_q == StData && decide) begin
            data_q    <= {maj, data_q[DATA_BITS-1:1]};
            par_acc_q <= par_acc_q ^ maj;
         end
         if (state_q == StData && wrap) bit_idx_q <= bit_idx_q + 1'b1;
         if (state_q == StParity && decide) begin
            par_err_q <= (PARITY == PAR_EVEN) ? (par_acc_q ^ maj) : ~(par_acc_q ^ maj);
         end
         if (state_q == StStop && decide && !maj) frame_err_q <= 1'b1;
         if (state_q == StStop && wrap)           stop_idx_q  <= 1'b1;
      end
   end

   uart_rx_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (push),
      .push_data (push_word),
      .pop       (rx_ready),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign rx_data       = head[DATA_BITS-1:0];
   assign rx_parity_err = head[DATA_BITS];
   assign rx_frame_err  = head[DATA_BITS+1];
   assign rx_valid      = !fifo_empty;

endmodule
